dvi_timing_stream: RTL

//  Parametrised video timing generator and pixel streamer for the DVI output path.

---
 rtl/dvi_timing_stream.sv | 111 +++++++++++
 1 files changed

// File: rtl/dvi_timing_stream.sv
// Video timing generator and pixel streamer: builds HS/VS/DE for a parameterised raster
// and pulls pixels over valid/ready during active video, substituting BORDER_COLOR on underflow.
module dvi_timing_stream #(
    parameter int              H_ACTIVE     = 640,
    parameter int              H_FP         = 16,
    parameter int              H_SYNC       = 96,
    parameter int              H_BP         = 48,
    parameter int              V_ACTIVE     = 480,
    parameter int              V_FP         = 10,
    parameter int              V_SYNC       = 2,
    parameter int              V_BP         = 33,
    parameter bit              HS_POL       = 1'b0,
    parameter bit              VS_POL       = 1'b0,
    parameter int              PIX_W        = 24,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '0,
    parameter int              UF_CNT_W     = 16
) (
    input  logic                USER_CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [PIX_W-1:0]    pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic                hs,
    output logic                vs,
    output logic                de,
    output logic [PIX_W-1:0]    rgb,
    output logic [11:0]         x,
    output logic [11:0]         y,
    output logic                frame_start,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] underflow_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
    localparam logic [12:0] H_ACT = 13'(H_ACTIVE);
    localparam logic [12:0] H_SS  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LST = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT = 13'(V_ACTIVE);
    localparam logic [12:0] V_SS  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SE  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LST = 13'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic [11:0] h_cnt, v_cnt;
    logic [12:0] h_ext, v_ext;
    logic        running, h_last, v_last, hs_on, vs_on;

    assign h_ext   = {1'b0, h_cnt};
    assign v_ext   = {1'b0, v_cnt};
    assign running = (state != IDLE);
    assign h_last  = (h_ext == H_LST);
    assign v_last  = (v_ext == V_LST);
    assign hs_on   = (h_ext >= H_SS) && (h_ext < H_SE);
    assign vs_on   = (v_ext >= V_SS) && (v_ext < V_SE);

    assign pix_ready = running && (h_ext < H_ACT) && (v_ext < V_ACT);

    always_ff @(posedge USER_CLK) begin
        if (reset) begin
            state           <= IDLE;
            h_cnt           <= '0;
            v_cnt           <= '0;
            hs              <= ~HS_POL;
            vs              <= ~VS_POL;
            de              <= 1'b0;
            rgb             <= BORDER_COLOR;
            x               <= '0;
            y               <= '0;
            frame_start     <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN:   if (enable) state <= RUN;
                         else if (h_last && v_last) state <= IDLE;
                default: state <= IDLE;
            endcase

            // counters sit at (0,0) in IDLE so the first RUN cycle is pixel (0,0)
            if (!running) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end

            hs          <= (running && hs_on) ? HS_POL : ~HS_POL;
            vs          <= (running && vs_on) ? VS_POL : ~VS_POL;
            de          <= pix_ready;
            x           <= h_cnt;
            y           <= v_cnt;
            frame_start <= pix_ready && (h_cnt == 12'd0) && (v_cnt == 12'd0);
            underflow   <= pix_ready && !pix_valid;
            rgb         <= (pix_ready && pix_valid) ? pix_data : BORDER_COLOR;

            if (pix_ready && !pix_valid && (underflow_count != {UF_CNT_W{1'b1}}))
                underflow_count <= underflow_count + 1'b1;
        end
    end
endmodule
